// File: rtl/layer6_pixel_bank_buffer.sv
// Frame buffer feeding the layer-6 2x2 max-pooling stage.
// Layer-5 pixels are written by (row, col) into four parity banks so the
// pooling stage can fetch a whole 2x2 window per cycle with zero latency.
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | accepting layer-5 writes; buffer_ready high
// DONE  | one-cycle frame-complete pulse; store_count cleared
// READ  | frame held for pooling; writes flagged as overflow
module layer6_pixel_bank_buffer #(
  parameter int IN_WIDTH = 16,
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_row,
  input  logic [ADDR_W-1:0] write_col,
  input  logic [DATA_W-1:0] write_data,
  output logic              buffer_ready,
  output logic              pixel_store_done,
  input  logic              read_pixel_signal,
  input  logic [ADDR_W-1:0] read_row_addr,
  input  logic [ADDR_W-1:0] read_col_addr,
  input  logic              layer6_calculation_done,
  output logic [DATA_W-1:0] output_data_even_even,
  output logic [DATA_W-1:0] output_data_even_odd,
  output logic [DATA_W-1:0] output_data_odd_even,
  output logic [DATA_W-1:0] output_data_odd_odd,
  output logic              write_overflow
);

  localparam int HALF  = IN_WIDTH / 2;
  localparam int DEPTH = HALF * HALF;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(IN_WIDTH * IN_WIDTH + 1);

  localparam logic [ADDR_W-1:0] IN_LIM   = ADDR_W'(IN_WIDTH);
  localparam logic [ADDR_W-1:0] HALF_LIM = ADDR_W'(HALF);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(IN_WIDTH * IN_WIDTH - 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    DONE = 2'd1,
    READ = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  store_count;

  logic [DATA_W-1:0] bank_ee [DEPTH];
  logic [DATA_W-1:0] bank_eo [DEPTH];
  logic [DATA_W-1:0] bank_oe [DEPTH];
  logic [DATA_W-1:0] bank_oo [DEPTH];

  logic              wr_in_range;
  logic              wr_accept;
  logic [ADDR_W-1:0] wr_row_half;
  logic [ADDR_W-1:0] wr_col_half;
  logic [IDX_W-1:0]  wr_idx;
  logic              rd_valid;
  logic [IDX_W-1:0]  rd_idx;

  assign wr_in_range = (write_row < IN_LIM) && (write_col < IN_LIM);
  assign wr_accept   = (state == FILL) && write_enable && wr_in_range;
  assign wr_row_half = write_row >> 1;
  assign wr_col_half = write_col >> 1;
  // Index is only used when the address is in range, so truncation is safe.
  assign wr_idx      = IDX_W'(wr_row_half * HALF_LIM + wr_col_half);

  assign rd_valid = (state == READ) && read_pixel_signal &&
                    (read_row_addr < HALF_LIM) && (read_col_addr < HALF_LIM);
  assign rd_idx   = IDX_W'(read_row_addr * HALF_LIM + read_col_addr);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next-state decode: the last accepted write and the DONE move share an edge.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (wr_accept && (store_count == LAST_CNT)) state_nxt = DONE;
      DONE: state_nxt = READ;
      READ: if (layer6_calculation_done) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // State-decoded handshake outputs; DONE lasts one cycle so the done flag is a pulse.
  always_comb begin
    buffer_ready     = 1'b0;
    pixel_store_done = 1'b0;
    case (state)
      FILL:    buffer_ready     = 1'b1;
      DONE:    pixel_store_done = 1'b1;
      default: ;
    endcase
  end

  // Accepted-pixel counter; duplicates count, out-of-range writes do not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                store_count <= '0;
    else if (state == DONE) store_count <= '0;
    else if (wr_accept)     store_count <= store_count + 1'b1;
  end

  // Sticky flag for writes arriving while the frame is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    write_overflow <= 1'b0;
    else if (write_enable && (state != FILL))   write_overflow <= 1'b1;
  end

  // Bank write, steered by row/col parity; memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      case ({write_row[0], write_col[0]})
        2'b00: bank_ee[wr_idx] <= write_data;
        2'b01: bank_eo[wr_idx] <= write_data;
        2'b10: bank_oe[wr_idx] <= write_data;
        2'b11: bank_oo[wr_idx] <= write_data;
        default: ;
      endcase
    end
  end

  // Zero-latency 2x2 window read, forced to zero outside a valid READ access.
  always_comb begin
    output_data_even_even = '0;
    output_data_even_odd  = '0;
    output_data_odd_even  = '0;
    output_data_odd_odd   = '0;
    if (rd_valid) begin
      output_data_even_even = bank_ee[rd_idx];
      output_data_even_odd  = bank_eo[rd_idx];
      output_data_odd_even  = bank_oe[rd_idx];
      output_data_odd_odd   = bank_oo[rd_idx];
    end
  end

endmodule

// File: tb/tb_layer6_pixel_bank_buffer.sv
// Directed + randomized bench for layer6_pixel_bank_buffer with a frame-level
// reference model (2D pixel array, fill count, overflow flag).
module tb_layer6_pixel_bank_buffer;
  localparam int IW = 16;
  localparam int DW = 128;
  localparam int AW = 16;
  localparam int HW = IW / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          write_enable;
  logic [AW-1:0] write_row, write_col;
  logic [DW-1:0] write_data;
  logic          buffer_ready, pixel_store_done;
  logic          read_pixel_signal;
  logic [AW-1:0] read_row_addr, read_col_addr;
  logic          layer6_calculation_done;
  logic [DW-1:0] ee, eo, oe, oo;
  logic          write_overflow;

  layer6_pixel_bank_buffer #(.IN_WIDTH(IW), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .write_enable(write_enable), .write_row(write_row), .write_col(write_col),
    .write_data(write_data), .buffer_ready(buffer_ready),
    .pixel_store_done(pixel_store_done), .read_pixel_signal(read_pixel_signal),
    .read_row_addr(read_row_addr), .read_col_addr(read_col_addr),
    .layer6_calculation_done(layer6_calculation_done),
    .output_data_even_even(ee), .output_data_even_odd(eo),
    .output_data_odd_even(oe), .output_data_odd_odd(oo),
    .write_overflow(write_overflow)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0] mdl [IW][IW];
  int  m_count;
  bit  m_fill;
  bit  m_over;
  int  order [IW*IW];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] raster_px(input int r, input int c);
    logic [15:0] v;
    v = 16'(r * IW + c);
    return {8{v}};
  endfunction

  // One write cycle, then compare handshake outputs against the frame model.
  task automatic wr(input int r, input int c, input logic [DW-1:0] d);
    bit exp_done;
    exp_done = 1'b0;
    write_enable = 1'b1;
    write_row = AW'(r);
    write_col = AW'(c);
    write_data = d;
    tick();
    write_enable = 1'b0;
    if (!m_fill) m_over = 1'b1;
    else if (r < IW && c < IW) begin
      mdl[r][c] = d;
      m_count++;
      if (m_count == IW * IW) begin
        exp_done = 1'b1;
        m_fill = 1'b0;
        m_count = 0;
      end
    end
    check("store_done", DW'(pixel_store_done), DW'(exp_done));
    check("ready", DW'(buffer_ready), DW'(m_fill));
    check("overflow", DW'(write_overflow), DW'(m_over));
  endtask

  // Same-cycle window read compared with the model; frame must be held (not filling).
  task automatic rd(input int rr, input int cc, input bit sig);
    logic [DW-1:0] xee, xeo, xoe, xoo;
    read_pixel_signal = sig;
    read_row_addr = AW'(rr);
    read_col_addr = AW'(cc);
    #1;
    xee = '0; xeo = '0; xoe = '0; xoo = '0;
    if (!m_fill && sig && rr < HW && cc < HW) begin
      xee = mdl[2*rr][2*cc];
      xeo = mdl[2*rr][2*cc+1];
      xoe = mdl[2*rr+1][2*cc];
      xoo = mdl[2*rr+1][2*cc+1];
    end
    check("rd_ee", ee, xee);
    check("rd_eo", eo, xeo);
    check("rd_oe", oe, xoe);
    check("rd_oo", oo, xoo);
    read_pixel_signal = 1'b0;
  endtask

  task automatic release_buf(input bit with_write);
    layer6_calculation_done = 1'b1;
    write_enable = with_write;
    write_row = '0;
    write_col = '0;
    write_data = '1;
    tick();
    layer6_calculation_done = 1'b0;
    write_enable = 1'b0;
    if (with_write) m_over = 1'b1;
    m_fill = 1'b1;
    m_count = 0;
    check("ready_after_release", DW'(buffer_ready), DW'(1'b1));
  endtask

  task automatic shuffle();
    for (int i = 0; i < IW * IW; i++) order[i] = i;
    for (int i = IW * IW - 1; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
  endtask

  initial begin
    logic [DW-1:0] rnd;
    rst = 1'b1;
    write_enable = 1'b0; write_row = '0; write_col = '0; write_data = '0;
    read_pixel_signal = 1'b0; read_row_addr = '0; read_col_addr = '0;
    layer6_calculation_done = 1'b0;
    m_count = 0; m_fill = 1'b1; m_over = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", DW'(buffer_ready), DW'(1'b1));
    check("rst_done", DW'(pixel_store_done), '0);
    check("rst_overflow", DW'(write_overflow), '0);
    rst = 1'b0;
    rd(0, 0, 1'b1);

    // Frame 1: raster order, data = {8{row*16+col}}.
    for (int r = 0; r < IW; r++)
      for (int c = 0; c < IW; c++)
        wr(r, c, raster_px(r, c));
    tick();
    check("done_pulse_end", DW'(pixel_store_done), '0);
    check("ready_in_read", DW'(buffer_ready), '0);

    rd(3, 5, 1'b1);
    check("win35_ee", ee, {8{16'd106}});
    check("win35_oo", oo, {8{16'd123}});
    read_pixel_signal = 1'b1; #1;
    check("win35_eo", eo, {8{16'd107}});
    check("win35_oe", oe, {8{16'd122}});
    read_pixel_signal = 1'b0;
    rd(8, 0, 1'b1);
    rd(0, 8, 1'b1);
    rd(3, 5, 1'b0);
    for (int k = 0; k < 8; k++) rd(int'($urandom_range(HW - 1, 0)), int'($urandom_range(HW - 1, 0)), 1'b1);

    // Write while held: ignored, flagged.
    wr(0, 0, '1);
    rd(0, 0, 1'b1);
    check("held_ee00", ee, '0);

    // Release with a coincident write; that write is dropped.
    release_buf(1'b1);

    // Frame 2: random order and data, with out-of-range writes mixed in.
    shuffle();
    for (int i = 0; i < IW * IW - 1; i++) begin
      if (i == 100) wr(16, int'($urandom_range(IW - 1, 0)), '1);
      if (i == 180) wr(int'($urandom_range(IW - 1, 0)), IW + int'($urandom_range(4, 0)), '1);
      if (i % 37 == 0) tick();
      rnd = {$urandom, $urandom, $urandom, $urandom};
      wr(order[i] / IW, order[i] % IW, rnd);
    end
    check("no_done_at_255", DW'(buffer_ready), DW'(1'b1));
    rnd = {$urandom, $urandom, $urandom, $urandom};
    wr(order[IW*IW-1] / IW, order[IW*IW-1] % IW, rnd);
    tick();
    for (int k = 0; k < 16; k++) rd(int'($urandom_range(HW, 0)), int'($urandom_range(HW, 0)), 1'(k % 5 != 0));

    // Reset mid-fill discards partial frame and clears overflow.
    release_buf(1'b0);
    for (int i = 0; i < 100; i++) wr(i / IW, i % IW, raster_px(i % IW, i / IW));
    rst = 1'b1;
    #2;
    check("midrst_ready", DW'(buffer_ready), DW'(1'b1));
    check("midrst_overflow", DW'(write_overflow), '0);
    tick();
    rst = 1'b0;
    m_count = 0; m_fill = 1'b1; m_over = 1'b0;
    shuffle();
    for (int i = 0; i < IW * IW; i++)
      wr(order[i] / IW, order[i] % IW, {$urandom, $urandom, $urandom, $urandom});
    tick();
    for (int k = 0; k < 8; k++) rd(int'($urandom_range(HW - 1, 0)), int'($urandom_range(HW - 1, 0)), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/layer6_pixel_bank_buffer.md
Name: layer6_pixel_bank_buffer

Overview:
- Frame buffer directly upstream of the layer-6 2x2 max-pooling stage.
- Captures the layer-5 output feature map, one 8-channel x 16-bit pixel per write, addressed by row/col.
- Stores pixels into four parity banks (even/odd row x even/odd col) and pulses pixel_store_done when the frame is complete.
- During pooling, serves all four pixels of a 2x2 window per cycle, with zero latency, from a pooled-grid (row, col) address.

Parameters:
- IN_WIDTH, 16, input feature-map height = width (even); pooled grid is IN_WIDTH/2.
- DATA_W, 128, pixel width (8 channels x 16 bit).
- ADDR_W, 16, row/col address width (matches `WORDLENGTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- write_enable  in  1  layer-5 pixel valid
- write_row  in  ADDR_W  layer-5 pixel row
- write_col  in  ADDR_W  layer-5 pixel col
- write_data  in  DATA_W  layer-5 pixel
- buffer_ready  out  1  high when writes are accepted
- pixel_store_done  out  1  one-cycle pulse: frame complete
- read_pixel_signal  in  1  pooling stage reading
- read_row_addr  in  ADDR_W  pooled row R
- read_col_addr  in  ADDR_W  pooled col C
- layer6_calculation_done  in  1  pooling finished; release buffer
- output_data_even_even  out  DATA_W  pixel(2R, 2C)
- output_data_even_odd  out  DATA_W  pixel(2R, 2C+1)
- output_data_odd_even  out  DATA_W  pixel(2R+1, 2C)
- output_data_odd_odd  out  DATA_W  pixel(2R+1, 2C+1)
- write_overflow  out  1  sticky: write attempted while not ready

Behaviour:
- Reset is asynchronous, active-high (rst); clock is clk.
- Reset values: state = FILL; store_count = 0; buffer_ready = 1; pixel_store_done = 0; write_overflow = 0; all read outputs = 0.
- Bank memory is not reset. Its contents are unobservable because read outputs are gated.
- Storage mapping:
  - A write to (r, c) goes to bank {r[0], c[0]}, index (r>>1)*(IN_WIDTH/2) + (c>>1).
  - Four banks, each (IN_WIDTH/2)^2 entries of DATA_W.
- State machine (registered state):
  - FILL:
    - buffer_ready = 1.
    - A write is accepted when write_enable = 1 and write_row < IN_WIDTH and write_col < IN_WIDTH. On acceptance the bank is written and store_count increments.
    - Out-of-range writes are dropped silently and not counted.
    - Duplicate addresses overwrite the entry and are still counted.
    - When an accepted write brings store_count to IN_WIDTH*IN_WIDTH, the next state is DONE.
  - DONE:
    - Lasts exactly one cycle.
    - pixel_store_done = 1 and buffer_ready = 0.
    - store_count clears to 0. Next state is READ.
  - READ:
    - buffer_ready = 0.
    - When layer6_calculation_done = 1, the next state is FILL.
    - Writes in READ or DONE are ignored and set write_overflow (sticky until rst).
- Read path, combinational with zero latency:
  - Outputs are valid in the same cycle as the address.
  - Outputs carry data only when state = READ, read_pixel_signal = 1, read_row_addr < IN_WIDTH/2 and read_col_addr < IN_WIDTH/2. Otherwise all four outputs are 0.
  - This satisfies the pooling stage, which registers the window on the clock edge after presenting the address.
- Simultaneous events:
  - layer6_calculation_done together with write_enable in READ: the write is ignored and flagged; the state returns to FILL; the first accepted write is the one in the following cycle.
  - The final accepted write and the DONE transition occur on the same edge.
- pixel_store_done is a one-cycle pulse only. The pooling stage's idle-state test must not see a level.
- Reset mid-fill or mid-read: returns to FILL with store_count = 0. The partial frame is discarded and must be rewritten in full.

Test Plan:
- Raster-write 256 pixels (IN_WIDTH = 16) with data = {8{row*16+col}} -> pixel_store_done high for exactly 1 cycle after the 256th write; buffer_ready drops in the same cycle.
- In READ, read_pixel_signal = 1 with R = 3, C = 5 -> same-cycle outputs ee = {8{16'd106}}, eo = {8{16'd107}}, oe = {8{16'd122}}, oo = {8{16'd123}}.
- Read with R = 8 or C = 8, or with read_pixel_signal = 0 -> all four outputs 0.
- Write in READ with write_data = all-ones -> memory unchanged (re-read R = 0, C = 0 gives ee = 0); write_overflow = 1 and held until rst.
- Pulse layer6_calculation_done, then write 255 pixels plus one write at row = 16 -> no pixel_store_done. One further in-range write -> pulse.
- Assert rst after 100 writes -> state FILL, count 0. 256 new writes are required before pixel_store_done.
